// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - shared op/state encodings for the HI/LO multiply-divide unit
package muldiv_unit_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// rtl/muldiv_unit_div_step.sv - one radix-2 restoring division step (combinational)
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_rem,
  input  logic [DATA_W-1:0] i_div,
  input  logic              i_bit,
  output logic [DATA_W-1:0] o_rem,
  output logic              o_q
);

  logic [DATA_W:0] w_shift;

  assign w_shift = {i_rem, i_bit};
  assign o_q     = (w_shift >= {1'b0, i_div});
  assign o_rem   = o_q ? DATA_W'(w_shift - {1'b0, i_div}) : w_shift[DATA_W-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit writing HI/LO
// Optional MULDIV_FAST_MUL_EN: single-cycle multiplier instead of shift-add.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] opa_i,
  input  logic [DATA_W-1:0] opb_i,
  input  logic              cancel_i,
  output logic              busy_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              wspreg_o
);

  localparam int CNT_W = $clog2(DATA_W);

  state_e            r_state, w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_hi, r_lo, r_b, r_hi_q, r_lo_q;
  logic              r_is_div, r_neg_q, r_neg_r, r_wspreg;

  logic              w_accept, w_sgn, w_a_neg, w_b_neg, w_div0, w_fast, w_qbit;
  logic [DATA_W-1:0] w_a_mag, w_b_mag, w_rem;
  logic [DATA_W:0]   w_sum;

  assign w_accept = (r_state == ST_IDLE) && start_i && !cancel_i;
  assign w_sgn    = op_is_signed(op_i);
  assign w_a_neg  = w_sgn & opa_i[DATA_W-1];
  assign w_b_neg  = w_sgn & opb_i[DATA_W-1];
  assign w_a_mag  = w_a_neg ? -opa_i : opa_i;
  assign w_b_mag  = w_b_neg ? -opb_i : opb_i;
  assign w_div0   = op_is_div(op_i) && (opb_i == '0);

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*DATA_W-1:0] w_prod_s;
  logic        [2*DATA_W-1:0] w_prod_u;
  assign w_prod_s = $signed(opa_i) * $signed(opb_i);
  assign w_prod_u = {{DATA_W{1'b0}}, opa_i} * {{DATA_W{1'b0}}, opb_i};
  assign w_fast   = !op_is_div(op_i);
`else
  assign w_fast   = 1'b0;
`endif

  // Division: r_hi is the partial remainder, r_lo shifts dividend bits out and quotient bits in.
  div_step #(.DATA_W(DATA_W)) u_div_step (
    .i_rem (r_hi),
    .i_div (r_b),
    .i_bit (r_lo[DATA_W-1]),
    .o_rem (w_rem),
    .o_q   (w_qbit)
  );

  // Multiplication: {r_hi,r_lo} is the product register, multiplier consumed from r_lo[0].
  assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(DATA_W+1){1'b0}});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = (w_div0 || w_fast) ? ST_DONE : ST_CALC;
      ST_CALC: if (r_cnt == CNT_W'(DATA_W-1)) w_next = ST_FIX;
      ST_FIX:  w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (cancel_i) w_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_hi_q   <= '0;
      r_lo_q   <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_wspreg <= 1'b0;
    end else begin
      r_wspreg <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_cnt    <= '0;
          r_is_div <= op_is_div(op_i);
          r_neg_q  <= w_a_neg ^ w_b_neg;
          r_neg_r  <= w_a_neg;
          if (w_div0) begin
            r_hi <= opa_i;
            r_lo <= '1;
          end else if (op_is_div(op_i)) begin
            r_hi <= '0;
            r_lo <= w_a_mag;
            r_b  <= w_b_mag;
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            {r_hi, r_lo} <= w_sgn ? w_prod_s : w_prod_u;
`else
            r_hi <= '0;
            r_lo <= w_b_mag;
            r_b  <= w_a_mag;
`endif
          end
        end
        ST_CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= {r_lo[DATA_W-2:0], w_qbit};
          end else begin
            {r_hi, r_lo} <= {w_sum, r_lo[DATA_W-1:1]};
          end
        end
        ST_FIX: begin
          if (r_is_div) begin
            if (r_neg_q) r_lo <= -r_lo;
            if (r_neg_r) r_hi <= -r_hi;
          end else if (r_neg_q) begin
            {r_hi, r_lo} <= -{r_hi, r_lo};
          end
        end
        ST_DONE: if (!cancel_i) begin
          r_hi_q   <= r_hi;
          r_lo_q   <= r_lo;
          r_wspreg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy_o   = (r_state != ST_IDLE);
  assign hi_o     = r_hi_q;
  assign lo_o     = r_lo_q;
  assign wspreg_o = r_wspreg;

endmodule
